sram_controller: RTL and testbench

- Memory-side responder for the MEM-stage load/store requests (mem_read/mem_write) issued by the pipeline's decode/control path.
- Converts one 32-bit word access into two sequential 16-bit accesses on an external asynchronous SRAM, padded to a fixed access time.
- Holds `ready` low while an access is in flight so the hazard/freeze logic can stall all pipeline registers.

---
 rtl/sram_controller_pkg.sv | 31 +++
 rtl/sram_controller.sv | 146 ++++++++++++++
 tb/tb_sram_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// rtl/sram_controller_pkg.sv - shared types and constants for the SRAM controller
//
// Purpose: FSM state encoding, default SRAM base address, bus widths and the
//          byte-address to SRAM-word mapping helper.
// Ports:   none (package).

package sram_controller_pkg;

  typedef enum logic [2:0] {
    SRAM_IDLE = 3'd0,
    SRAM_LO   = 3'd1,
    SRAM_HI   = 3'd2,
    SRAM_WAIT = 3'd3,
    SRAM_DONE = 3'd4
  } sram_state_t;

  localparam logic [31:0] SRAM_BASE_DEFAULT = 32'd1024;
  localparam int          SRAM_DW           = 16;
  localparam int          WORD_W            = 32;
  localparam int          CNT_W             = 3;

  // 32-bit word index of a byte address, relative to the SRAM base.
  // Wraps modulo 2^32 below the base; no range checking.
  function automatic logic [31:0] sram_word(input logic [31:0] byte_addr,
                                            input logic [31:0] base);
    logic [31:0] offset;
    offset = byte_addr - base;
    return offset >> 2;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store responder over a 16-bit async SRAM
//
// Purpose: splits each 32-bit access into a low and a high halfword access,
//          pads the access to ACCESS_CYCLES and holds ready low meanwhile so
//          the pipeline freezes.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rd_en, wr_en       load / store request from the MEM stage
//   address            byte address
//   write_data         store data
//   read_data          registered load data
//   ready              1 = MEM stage may advance, 0 = freeze
//   sram_addr          SRAM halfword address
//   sram_dq_o/_i/_oe   SRAM data out / in / output enable
//   sram_we_n/oe_n     active-low write strobe / output enable
//   sram_ce_n/ub_n/lb_n  tied active

module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE     = SRAM_BASE_DEFAULT,
  parameter int          ACCESS_CYCLES = 6,   // minimum 3, maximum 9
  parameter int          SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_o,
  input  logic [SRAM_DW-1:0] sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int WW = SRAM_AW - 1;

  sram_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [WW-1:0]     word_q;
  logic [WORD_W-1:0] wdata_q;
  logic              req;

  assign req       = rd_en | wr_en;
  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SRAM_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. cnt_q is 0 in LO, so cycle index since the request is
  // cnt_q+1; WAIT ends in cycle ACCESS_CYCLES-1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SRAM_IDLE: if (req) state_d = SRAM_LO;
      SRAM_LO:   state_d = SRAM_HI;
      SRAM_HI:   state_d = (ACCESS_CYCLES == 3) ? SRAM_DONE : SRAM_WAIT;
      SRAM_WAIT: if (cnt_q == CNT_W'(ACCESS_CYCLES - 2)) state_d = SRAM_DONE;
      SRAM_DONE: state_d = SRAM_IDLE;
      default:   state_d = SRAM_IDLE;
    endcase
  end

  // Outputs. Reads only ever assert oe_n; writes only dq_oe/we_n, so the two
  // never overlap.
  always_comb begin
    ready      = 1'b0;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state_q)
      SRAM_IDLE: ready = ~req;
      SRAM_LO: begin
        sram_addr = {word_q, 1'b0};
        if (write_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
          sram_dq_o  = wdata_q[15:0];
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      SRAM_HI: begin
        sram_addr = {word_q, 1'b1};
        if (write_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = 1'b0;
          sram_dq_o  = wdata_q[31:16];
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      SRAM_DONE: ready = 1'b1;
      default: ;
    endcase
  end

  // Request latch, wait counter and load data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        SRAM_IDLE: begin
          if (req) begin
            write_q <= wr_en;   // store wins when both are requested
            word_q  <= WW'(sram_word(address, SRAM_BASE));
            wdata_q <= write_data;
            cnt_q   <= '0;
          end
        end
        SRAM_LO: begin
          if (!write_q) read_data[15:0] <= sram_dq_i;
          cnt_q <= cnt_q + 3'd1;
        end
        SRAM_HI: begin
          if (!write_q) read_data[31:16] <= sram_dq_i;
          cnt_q <= cnt_q + 3'd1;
        end
        SRAM_WAIT: cnt_q <= cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller

module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic        s3_rd_en, s3_wr_en;
  logic [31:0] s3_address, s3_write_data, s3_read_data;
  logic        s3_ready;
  logic [17:0] s3_sram_addr;
  logic [15:0] s3_sram_dq_o, s3_sram_dq_i;
  logic        s3_dq_oe, s3_we_n, s3_oe_n, s3_ce_n, s3_ub_n, s3_lb_n;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] shadow[logic [31:0]];
  logic [31:0] last_read;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_controller #(.ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .rd_en(s3_rd_en), .wr_en(s3_wr_en), .address(s3_address),
    .write_data(s3_write_data), .read_data(s3_read_data), .ready(s3_ready),
    .sram_addr(s3_sram_addr), .sram_dq_o(s3_sram_dq_o), .sram_dq_i(s3_sram_dq_i),
    .sram_dq_oe(s3_dq_oe), .sram_we_n(s3_we_n), .sram_oe_n(s3_oe_n),
    .sram_ce_n(s3_ce_n), .sram_ub_n(s3_ub_n), .sram_lb_n(s3_lb_n)
  );

  // Asynchronous SRAM models: combinational read, write captured on the edge
  logic [15:0] mem  [0:(1<<18)-1];
  logic [15:0] mem3 [0:(1<<18)-1];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;
    if (!s3_we_n && s3_dq_oe) mem3[s3_sram_addr] <= s3_sram_dq_o;
  end
  assign sram_dq_i    = !sram_oe_n ? mem[sram_addr] : 16'h0000;
  assign s3_sram_dq_i = !s3_oe_n ? mem3[s3_sram_addr] : 16'h0000;

  // One access on the 6-cycle DUT; entered just after a rising edge
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit keep);
    logic [17:0] lo, ea;
    logic [31:0] exp;
    logic [15:0] ed;
    lo = 18'(((addr - 32'd1024) >> 2) << 1);
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    if (wr) shadow[addr] = data;
    else exp_q.push_back(shadow.exists(addr) ? shadow[addr] : 32'h0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (ready !== (c == 6)) begin
        n_fail++; $display("FAIL ready_c%0d addr=%0d: got %b want %b", c, addr, ready, (c == 6));
      end
      if (c == 1 || c == 2) begin
        ea = (c == 1) ? lo : (lo | 18'd1);
        ed = (c == 1) ? data[15:0] : data[31:16];
        n_tests++;
        if (sram_addr !== ea) begin
          n_fail++; $display("FAIL sram_addr_c%0d: got %0d want %0d", c, sram_addr, ea);
        end
        n_tests++;
        if (wr) begin
          if ({sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o} !== {3'b011, ed}) begin
            n_fail++; $display("FAIL write_strobes_c%0d: got we_n/oe_n/oe/dq=%b%b%b/%h want 011/%h",
                               c, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o, ed);
          end
        end else if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b100) begin
          n_fail++; $display("FAIL read_strobes_c%0d: got we_n/oe_n/oe=%b%b%b want 100",
                             c, sram_we_n, sram_oe_n, sram_dq_oe);
        end
      end else begin
        n_tests++;
        if ({sram_we_n, sram_oe_n, sram_dq_oe} !== 3'b110) begin
          n_fail++; $display("FAIL idle_strobes_c%0d: got we_n/oe_n/oe=%b%b%b want 110",
                             c, sram_we_n, sram_oe_n, sram_dq_oe);
        end
        if (c >= 3 && c <= 5) begin
          n_tests++;
          if (sram_addr !== 18'd0) begin
            n_fail++; $display("FAIL wait_addr_c%0d: got %0d want 0", c, sram_addr);
          end
        end
      end
      if (c == 6) begin
        if (!wr) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
          last_read = exp;
        end else begin
          exp = last_read;
        end
        n_tests++;
        if (read_data !== exp) begin
          n_fail++; $display("FAIL read_data addr=%0d: got %h want %h", addr, read_data, exp);
        end
      end
    end
    @(posedge clk); #1;
    if (!keep) begin rd_en = 1'b0; wr_en = 1'b0; end
  endtask

  task automatic test_reset;
    rst = 1'b1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    s3_rd_en = 0; s3_wr_en = 0; s3_address = 0; s3_write_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({read_data, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe} !== {32'h0, 18'h0, 3'b110}) begin
      n_fail++; $display("FAIL reset_state: got rd=%h addr=%0d we_n/oe_n/oe=%b%b%b want 0/0/110",
                         read_data, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe);
    end
    n_tests++;
    if ({sram_ce_n, sram_ub_n, sram_lb_n} !== 3'b000) begin
      n_fail++; $display("FAIL tied_enables: got %b%b%b want 000", sram_ce_n, sram_ub_n, sram_lb_n);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_read = 32'h0;
  endtask

  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if ({ready, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
        n_fail++; $display("FAIL idle_%0d: got ready/we_n/oe_n/oe=%b%b%b%b want 1110",
                           i, ready, sram_we_n, sram_oe_n, sram_dq_oe);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    access(1'b0, 1'b1, 32'd1024, 32'h11112222, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h33334444, 1'b0);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
  endtask

  task automatic test_both_enables;
    access(1'b1, 1'b1, 32'd1024, 32'h0000ABCD, 1'b0);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_write;
    wr_en = 1'b1; address = 32'd2048; write_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({sram_we_n, sram_oe_n, sram_dq_oe, read_data, sram_addr, ready} !== {3'b110, 32'h0, 18'h0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid_write: got we_n/oe_n/oe=%b%b%b rd=%h addr=%0d ready=%b want 110/0/0/0",
                         sram_we_n, sram_oe_n, sram_dq_oe, read_data, sram_addr, ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: got %b want 1", ready);
    end
    last_read = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep;
    logic [31:0] exp;
    for (int k = 0; k < 2; k++) begin
      s3_wr_en = (k == 0); s3_rd_en = (k == 1);
      s3_address = 32'd1024; s3_write_data = 32'h5A5AA5A5;
      if (k == 1) exp_q.push_back(32'h5A5AA5A5);
      for (int c = 0; c <= 3; c++) begin
        @(negedge clk);
        n_tests++;
        if (s3_ready !== (c == 3)) begin
          n_fail++; $display("FAIL ac3_ready_k%0d_c%0d: got %b want %b", k, c, s3_ready, (c == 3));
        end
        if (k == 1 && c == 3) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
          n_tests++;
          if (s3_read_data !== exp) begin
            n_fail++; $display("FAIL ac3_read_data: got %h want %h", s3_read_data, exp);
          end
        end
      end
      @(posedge clk); #1;
      s3_wr_en = 1'b0; s3_rd_en = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_write_read();
    test_back_to_back();
    test_both_enables();
    test_reset_mid_write();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
